l2_req_arbiter: RTL and testbench



---
 rtl/l2_req_arbiter_pkg.sv | 25 ++
 rtl/l2_req_arbiter_if.sv | 46 ++++
 rtl/l2_req_arbiter_rr_arbiter.sv | 62 ++++++
 rtl/l2_req_arbiter.sv | 123 ++++++++++++
 tb/tb_l2_req_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_req_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : l2_arb_pkg
// Brief   : Shared types and defaults for the L2 request arbiter.
// Revision: 1.0
// ============================================================================
package l2_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2
    } state_t;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_LINE_BYTES = 32;

    // Owner index width; a single bit is kept even for degenerate counts.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_req_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : l2_req_arbiter_if
// Brief   : Requester-side and L2-side bus bundle of the L2 request arbiter.
// Revision: 1.0
// ============================================================================
interface l2_req_arbiter_if
    import l2_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_BYTES * 8
) ();
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_rw;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*LINE_W-1:0] req_wline;
    logic [NREQ-1:0]        resp_valid;
    logic [LINE_W-1:0]      resp_rline;
    logic                   l2_req_valid;
    logic                   l2_req_ready;
    logic                   l2_req_rw;
    logic [ADDR_W-1:0]      l2_req_addr;
    logic [LINE_W-1:0]      l2_req_wline;
    logic                   l2_resp_valid;
    logic [LINE_W-1:0]      l2_resp_rline;

    // Arbiter view
    modport slave (
        input  req_valid, req_rw, req_addr, req_wline,
        input  l2_req_ready, l2_resp_valid, l2_resp_rline,
        output req_ready, resp_valid, resp_rline,
        output l2_req_valid, l2_req_rw, l2_req_addr, l2_req_wline
    );

    // Environment view (requesters plus L2)
    modport master (
        output req_valid, req_rw, req_addr, req_wline,
        output l2_req_ready, l2_resp_valid, l2_resp_rline,
        input  req_ready, resp_valid, resp_rline,
        input  l2_req_valid, l2_req_rw, l2_req_addr, l2_req_wline
    );
endinterface
`default_nettype wire

// File: rtl/l2_req_arbiter_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin grant selection; L2ARB_FIXED_PRIO_EN selects fixed
//           lowest-index priority and removes the pointer register.
// Revision: 1.0
// ============================================================================
module rr_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = owner_w(NREQ)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [NREQ-1:0]  req,
    input  wire logic             advance,
    output logic      [NREQ-1:0]  grant,
    output logic      [IDX_W-1:0] grant_idx
);
    logic [IDX_W-1:0] w_ptr;

`ifdef L2ARB_FIXED_PRIO_EN
    logic unused_ports;
    assign w_ptr        = '0;
    assign unused_ports = clk ^ rst ^ advance;
`else
    logic [IDX_W-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    // Search upward from the pointer with wrap-around; first hit wins.
    always_comb begin : p_search
        int  k;
        logic found;
        k         = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(w_ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : l2_req_arbiter
// Brief   : Shares the blocking L2 upper port among NREQ L1 requesters and
//           routes read responses back (L2ARB_FIXED_PRIO_EN: fixed priority).
// Revision: 1.0
// ============================================================================
module l2_req_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int LINE_W     = LINE_BYTES * 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    l2_req_arbiter_if.slave    bus
);
    localparam int IDX_W = owner_w(NREQ);

    state_t            r_state;
    state_t            w_next;
    logic [NREQ-1:0]   w_grant;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_any;
    logic              w_advance;
    logic [NREQ-1:0]   w_ready;

    logic [IDX_W-1:0]  r_owner;
    logic              r_l2_valid;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wline;
    logic [NREQ-1:0]   r_resp_valid;
    logic [LINE_W-1:0] r_resp_rline;

    assign w_any = |bus.req_valid;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .advance   (w_advance),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_ready   = '0;
        w_advance = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_ready   = w_grant;
                    w_advance = 1'b1;
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_l2_valid && bus.l2_req_ready)
                    w_next = r_rw ? S_IDLE : S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (bus.l2_resp_valid) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= '0;
            r_l2_valid   <= 1'b0;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_wline      <= '0;
            r_resp_valid <= '0;
            r_resp_rline <= '0;
        end else begin
            r_resp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner    <= w_grant_idx;
                        r_rw       <= bus.req_rw[w_grant_idx];
                        r_addr     <= bus.req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
                        r_wline    <= bus.req_wline[int'(w_grant_idx)*LINE_W +: LINE_W];
                        r_l2_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.l2_req_ready) r_l2_valid <= 1'b0;
                end
                S_WAIT_RESP: begin
                    // Responses outside this state are deliberately dropped.
                    if (bus.l2_resp_valid) begin
                        r_resp_valid[r_owner] <= 1'b1;
                        r_resp_rline          <= bus.l2_resp_rline;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.l2_req_valid = r_l2_valid;
    assign bus.l2_req_rw    = r_rw;
    assign bus.l2_req_addr  = r_addr;
    assign bus.l2_req_wline = r_wline;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_rline   = r_resp_rline;

endmodule
`default_nettype wire

// File: tb/tb_l2_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_l2_req_arbiter
// Brief   : Directed and randomized bench with a transaction-level model.
// Revision: 1.0
// ============================================================================
module tb_l2_req_arbiter;
    localparam int NREQ       = 2;
    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = 32;
    localparam int LINE_W     = LINE_BYTES * 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_req_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    l2_req_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level model of the arbiter
    bit                m_busy, m_sent, m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wline, m_rline;
    logic [NREQ-1:0]   m_resp;
    int                m_owner, m_ptr, m_last_grant;
    int                m_reads_acc, dut_pulses;
    logic [NREQ-1:0]   obs_ready;
    bit                l2_owe;
    int                l2_cnt;
    bit                pend [NREQ];

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int start);
        for (int i = 0; i < NREQ; i++)
            if (v[(start + i) % NREQ]) return (start + i) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_sent = 0; m_rw = 0; m_addr = '0; m_wline = '0;
        m_rline = '0; m_resp = '0; m_owner = 0; m_ptr = 0; m_last_grant = -1;
        l2_owe = 0; l2_cnt = 0;
    endtask

    task automatic cycle();
        int g;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
`ifdef L2ARB_FIXED_PRIO_EN
        g = m_busy ? -1 : pick(bus.req_valid, 0);
`else
        g = m_busy ? -1 : pick(bus.req_valid, m_ptr);
`endif
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        obs_ready = bus.req_ready;
        chk("req_ready", bus.req_ready, exp_ready);
        m_last_grant = g;
        m_resp = '0;
        if (g >= 0) begin
            m_busy  = 1; m_sent = 0; m_owner = g;
            m_rw    = bus.req_rw[g];
            m_addr  = bus.req_addr[g*ADDR_W +: ADDR_W];
            m_wline = bus.req_wline[g*LINE_W +: LINE_W];
            m_ptr   = (g + 1) % NREQ;
        end else if (m_busy && !m_sent) begin
            if (bus.l2_req_ready) begin
                if (m_rw) m_busy = 0;
                else begin
                    m_sent = 1; m_reads_acc++;
                    l2_owe = 1; l2_cnt = $urandom_range(0, 3);
                end
            end
        end else if (m_busy && m_sent && bus.l2_resp_valid) begin
            m_resp[m_owner] = 1'b1;
            m_rline = bus.l2_resp_rline;
            m_busy = 0;
        end
        @(posedge clk);
        #1;
        chk("l2_req_valid", bus.l2_req_valid, m_busy && !m_sent);
        chk("l2_req_rw", bus.l2_req_rw, m_rw);
        chk("l2_req_addr", bus.l2_req_addr, m_addr);
        chk("l2_req_wline", bus.l2_req_wline, m_wline);
        chk("resp_valid", bus.resp_valid, m_resp);
        chk("resp_rline", bus.resp_rline, m_rline);
        dut_pulses += $countones(bus.resp_valid);
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wline = '0;
        bus.l2_req_ready = 0; bus.l2_resp_valid = 0; bus.l2_resp_rline = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic rand_drive(input bit allow_new);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && allow_new && $urandom_range(0, 2) == 0) begin
                pend[i] = 1;
                a = $urandom;
                a[4:0] = '0;
                bus.req_rw[i] = 1'($urandom_range(0, 1));
                bus.req_addr[i*ADDR_W +: ADDR_W] = a;
                bus.req_wline[i*LINE_W +: LINE_W] = rand_line();
            end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                pend[i] = 0;
            end
            bus.req_valid[i] = pend[i];
        end
        bus.l2_req_ready = ($urandom_range(0, 3) != 0);
        bus.l2_resp_rline = rand_line();
        if (l2_owe) begin
            if (l2_cnt == 0) begin
                bus.l2_resp_valid = 1; l2_owe = 0;
            end else begin
                bus.l2_resp_valid = 0; l2_cnt--;
            end
        end else begin
            bus.l2_resp_valid = ($urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        int grants [4];
        int n, budget;
        bit exp0;

        // Reset state
        clear_inputs();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_l2_req_valid", bus.l2_req_valid, 0);
        chk("rst_l2_req_addr", bus.l2_req_addr, 0);
        chk("rst_l2_req_wline", bus.l2_req_wline, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        rst = 0;

        // Single read, response 3 cycles after handshake
        bus.req_valid = 2'b01; bus.req_rw = 2'b00;
        bus.req_addr[0 +: ADDR_W] = 32'h0000_0040;
        cycle();
        chk("rd_grant", obs_ready, 2'b01);
        chk("rd_addr", bus.l2_req_addr, 32'h0000_0040);
        chk("rd_l2_valid", bus.l2_req_valid, 1);
        bus.req_valid = '0; bus.l2_req_ready = 1;
        cycle();
        bus.l2_req_ready = 0;
        cycle();
        cycle();
        bus.l2_resp_valid = 1; bus.l2_resp_rline = {32{8'hAA}};
        cycle();
        chk("rd_resp_valid", bus.resp_valid, 2'b01);
        chk("rd_resp_line", bus.resp_rline, {32{8'hAA}});
        bus.l2_resp_valid = 0;
        cycle();
        chk("rd_resp_pulse_end", bus.resp_valid, 2'b00);

        // Contention: both ports request continuously
        do_reset();
        bus.req_valid = 2'b11; bus.req_rw = 2'b11; bus.l2_req_ready = 1;
        bus.req_addr = {32'h0000_0200, 32'h0000_0100};
        n = 0; budget = 0;
        while (n < 4 && budget < 30) begin
            cycle();
            if (m_last_grant >= 0) begin
                grants[n] = m_last_grant;
                n++;
            end
            budget++;
        end
        chk("cont_grant_count", n, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef L2ARB_FIXED_PRIO_EN
            chk("cont_grant_seq", grants[k], 0);
`else
            chk("cont_grant_seq", grants[k], k % 2);
`endif
        end

        // Writeback from port 1 with immediate L2 ready
        do_reset();
        bus.req_valid = 2'b10; bus.req_rw = 2'b10; bus.l2_req_ready = 1;
        bus.req_addr[ADDR_W +: ADDR_W] = 32'h0000_1000;
        bus.req_wline[LINE_W +: LINE_W] = {32{8'h55}};
        cycle();
        chk("wb_grant", obs_ready, 2'b10);
        chk("wb_rw", bus.l2_req_rw, 1);
        chk("wb_addr", bus.l2_req_addr, 32'h0000_1000);
        chk("wb_wline", bus.l2_req_wline, {32{8'h55}});
        bus.req_valid = '0;
        cycle();
        bus.req_valid = 2'b01; bus.req_rw = 2'b00;
        cycle();
        chk("wb_next_grant", obs_ready, 2'b01);
        chk("wb_no_resp", bus.resp_valid, 2'b00);

        // Backpressure with a competing requester
        do_reset();
        bus.req_valid = 2'b01; bus.req_rw = 2'b00;
        bus.req_addr[0 +: ADDR_W] = 32'h0000_0080;
        bus.req_wline[0 +: LINE_W] = {32{8'h3C}};
        cycle();
        bus.req_valid = 2'b10;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("bp_addr", bus.l2_req_addr, 32'h0000_0080);
            chk("bp_wline", bus.l2_req_wline, {32{8'h3C}});
            chk("bp_no_ready", obs_ready, 2'b00);
        end

        // Spurious response while idle
        do_reset();
        bus.l2_resp_valid = 1; bus.l2_resp_rline = {32{8'h99}};
        cycle();
        chk("spur_resp_valid", bus.resp_valid, 2'b00);
        bus.l2_resp_valid = 0;

        // Asynchronous reset while waiting for a read response
        do_reset();
        bus.req_valid = 2'b10; bus.req_rw = 2'b00;
        bus.req_addr[ADDR_W +: ADDR_W] = 32'h0000_2000;
        bus.req_wline[LINE_W +: LINE_W] = {32{8'hF0}};
        cycle();
        bus.req_valid = '0; bus.l2_req_ready = 1;
        cycle();
        bus.l2_req_ready = 0;
        rst = 1;
        #2;
        chk("arst_l2_valid", bus.l2_req_valid, 0);
        chk("arst_addr", bus.l2_req_addr, 0);
        chk("arst_wline", bus.l2_req_wline, 0);
        chk("arst_resp_valid", bus.resp_valid, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        bus.l2_resp_valid = 1; bus.l2_resp_rline = {32{8'h77}};
        cycle();
        chk("arst_late_resp", bus.resp_valid, 2'b00);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        m_reads_acc = 0; dut_pulses = 0;
        for (int c = 0; c < 3000; c++) begin
            rand_drive(1);
            cycle();
            if (m_last_grant >= 0) pend[m_last_grant] = 0;
        end
        budget = 0;
        exp0 = 1;
        while (exp0 && budget < 300) begin
            rand_drive(0);
            cycle();
            if (m_last_grant >= 0) pend[m_last_grant] = 0;
            exp0 = m_busy;
            for (int i = 0; i < NREQ; i++) if (pend[i]) exp0 = 1;
            budget++;
        end
        chk("drain_done", exp0, 0);
        chk("read_resp_count", dut_pulses, m_reads_acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
